sha_nonce_feeder: RTL and testbench

//  Issue side of the SHA message-schedule stage: drives en/nonce/M/Hin into the W-expansion block.

---
 rtl/sha_nonce_feeder_pkg.sv | 30 +++
 rtl/sha_nonce_feeder_pad_block.sv | 35 +++
 rtl/sha_nonce_feeder.sv | 158 +++++++++++++++
 tb/tb_sha_nonce_feeder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_nonce_feeder_pkg.sv
// Shared constants, types and helpers for the SHA nonce feeder.
//  WORD_S / MSG_S / H_SIZE : SHA-256 word, message block and state widths
//  TAIL_S                  : width of the header tail (merkle tail, time, nbits)
//  DELAY                   : default number of cycles between block issues
//  SHA_PAD_WORD            : first padding word after the 640-bit header
//  BTC_LEN_WORD            : message length word (640 bits) in the last slot
package sha_nonce_feeder_pkg;

    localparam int WORD_S = 32;
    localparam int MSG_S  = 512;
    localparam int H_SIZE = 256;
    localparam int TAIL_S = 96;
    localparam int DELAY  = 4;

    localparam logic [WORD_S-1:0] SHA_PAD_WORD = 32'h8000_0000;
    localparam logic [WORD_S-1:0] BTC_LEN_WORD = 32'h0000_0280;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_FIN
    } feeder_state_t;

    // Reverse byte order of one 32-bit word.
    function automatic logic [WORD_S-1:0] bswap32(input logic [WORD_S-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha_nonce_feeder_pad_block.sv
// Combinational builder of the padded second-chunk block of a Bitcoin header.
//  tail  in  96   header bytes 64..75, MSB word first
//  nonce in  32   nonce placed in word 3 (optionally byte-swapped)
//  block out 512  16 words, word 0 in the MSBs
// Layout: tail0, tail1, tail2, nonce, pad word, ten zero words, length word.
module sha_nonce_feeder_pad_block
    import sha_nonce_feeder_pkg::*;
#(
    parameter bit BSWAP = 1'b0
) (
    input  logic [TAIL_S-1:0] tail,
    input  logic [WORD_S-1:0] nonce,
    output logic [MSG_S-1:0]  block
);

    logic [WORD_S-1:0] words [16];

    assign words[0]  = tail[TAIL_S-1 -: WORD_S];
    assign words[1]  = tail[TAIL_S-1-WORD_S -: WORD_S];
    assign words[2]  = tail[WORD_S-1:0];
    assign words[3]  = BSWAP ? bswap32(nonce) : nonce;
    assign words[4]  = SHA_PAD_WORD;
    assign words[15] = BTC_LEN_WORD;

    genvar gi;
    generate
        for (gi = 5; gi < 15; gi++) begin : g_zero_words
            assign words[gi] = '0;
        end
        for (gi = 0; gi < 16; gi++) begin : g_pack
            assign block[MSG_S-1-WORD_S*gi -: WORD_S] = words[gi];
        end
    endgenerate

endmodule

// File: rtl/sha_nonce_feeder.sv
// Issue side of the SHA message-schedule stage. Latches a job (midstate, header
// tail, nonce range), then sweeps the nonce range issuing one padded block every
// ISSUE_GAP cycles (ISSUE_GAP >= 2).
//  clk, reset       clock and synchronous active-high reset
//  start            1-cycle pulse: latch job and begin sweep (ignored while busy)
//  stop             abort sweep; no en after the stop cycle
//  midstate         SHA-256 state after chunk 0, forwarded as Hin
//  hdr_tail         header bytes 64..75 as 3 words, MSB word first
//  nonce_first/last inclusive nonce range, modulo 2^32
//  en               1-cycle issue strobe
//  nonce, M         current nonce and padded block, held until next en
//  Hin              latched midstate, held for the whole job
//  busy, done       sweep in progress / 1-cycle end pulse
//  aborted          end came from stop, held until next start
module sha_nonce_feeder
    import sha_nonce_feeder_pkg::*;
#(
    parameter int ISSUE_GAP   = DELAY,
    parameter bit NONCE_BSWAP = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [H_SIZE-1:0] midstate,
    input  logic [TAIL_S-1:0] hdr_tail,
    input  logic [WORD_S-1:0] nonce_first,
    input  logic [WORD_S-1:0] nonce_last,
    output logic              en,
    output logic [WORD_S-1:0] nonce,
    output logic [MSG_S-1:0]  M,
    output logic [H_SIZE-1:0] Hin,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int GAP_W = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;

    feeder_state_t     state_reg, state_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    logic [WORD_S-1:0] nonce_reg, nonce_next;
    logic [WORD_S-1:0] last_reg, last_next;
    logic [TAIL_S-1:0] tail_reg, tail_next;
    logic [H_SIZE-1:0] hin_reg, hin_next;
    logic [MSG_S-1:0]  m_reg, m_next;
    logic              en_reg, done_reg, busy_reg, aborted_reg;
    logic              start_job, abort_set;

    // Block for the nonce about to be issued; registered only on ISSUE entry
    // so M never moves during GAP.
    sha_nonce_feeder_pad_block #(
        .BSWAP (NONCE_BSWAP)
    ) u_pad (
        .tail  (tail_next),
        .nonce (nonce_next),
        .block (m_next)
    );

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        nonce_next = nonce_reg;
        last_next  = last_reg;
        tail_next  = tail_reg;
        hin_next   = hin_reg;
        start_job  = 1'b0;
        abort_set  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    start_job  = 1'b1;
                    state_next = ST_ISSUE;
                    nonce_next = nonce_first;
                    last_next  = nonce_last;
                    tail_next  = hdr_tail;
                    hin_next   = midstate;
                end
            end
            ST_ISSUE: begin
                // Reaching the last nonce is a normal finish even if stop is high.
                if (nonce_reg == last_reg) begin
                    state_next = ST_FIN;
                end else if (stop) begin
                    state_next = ST_FIN;
                    abort_set  = 1'b1;
                end else begin
                    state_next = ST_GAP;
                    gap_next   = GAP_W'(ISSUE_GAP - 2);
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_next = ST_FIN;
                    abort_set  = 1'b1;
                end else if (gap_reg == '0) begin
                    state_next = ST_ISSUE;
                    nonce_next = nonce_reg + WORD_S'(1);
                end else begin
                    gap_next = gap_reg - GAP_W'(1);
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            gap_reg     <= '0;
            nonce_reg   <= '0;
            last_reg    <= '0;
            tail_reg    <= '0;
            hin_reg     <= '0;
            m_reg       <= '0;
            en_reg      <= 1'b0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            gap_reg   <= gap_next;
            nonce_reg <= nonce_next;
            last_reg  <= last_next;
            tail_reg  <= tail_next;
            hin_reg   <= hin_next;
            en_reg    <= (state_next == ST_ISSUE);
            done_reg  <= (state_next == ST_FIN);
            if (state_next == ST_ISSUE) begin
                m_reg <= m_next;
            end
            if (start_job) begin
                busy_reg    <= 1'b1;
                aborted_reg <= 1'b0;
            end else if (state_next == ST_FIN) begin
                busy_reg <= 1'b0;
            end
            if (abort_set) begin
                aborted_reg <= 1'b1;
            end
        end
    end

    assign en      = en_reg;
    assign nonce   = nonce_reg;
    assign M       = m_reg;
    assign Hin     = hin_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign aborted = aborted_reg;

endmodule

// File: tb/tb_sha_nonce_feeder.sv
// Bench for sha_nonce_feeder: table-driven jobs, randomized jobs and a few
// hand-written corner sequences, checked cycle by cycle against a timing model
// derived from the issue rules (issue cycles 1, 1+G, 1+2G, ... after start).
module tb_sha_nonce_feeder;

    localparam int G = 4;

    logic         clk = 1'b0;
    logic         reset, start, stop;
    logic [255:0] midstate;
    logic [95:0]  hdr_tail;
    logic [31:0]  nonce_first, nonce_last;

    logic         en, busy, done, aborted;
    logic [31:0]  nonce;
    logic [511:0] M;
    logic [255:0] Hin;

    logic         en_s, busy_s, done_s, aborted_s;
    logic [31:0]  nonce_s;
    logic [511:0] m_s;
    logic [255:0] hin_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sha_nonce_feeder #(.ISSUE_GAP(G), .NONCE_BSWAP(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .midstate(midstate), .hdr_tail(hdr_tail),
        .nonce_first(nonce_first), .nonce_last(nonce_last),
        .en(en), .nonce(nonce), .M(M), .Hin(Hin),
        .busy(busy), .done(done), .aborted(aborted)
    );

    sha_nonce_feeder #(.ISSUE_GAP(G), .NONCE_BSWAP(1'b1)) dut_sw (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .midstate(midstate), .hdr_tail(hdr_tail),
        .nonce_first(nonce_first), .nonce_last(nonce_last),
        .en(en_s), .nonce(nonce_s), .M(m_s), .Hin(hin_s),
        .busy(busy_s), .done(done_s), .aborted(aborted_s)
    );

    typedef struct {
        logic [31:0] first;
        logic [31:0] last;
        int          stop_c;   // cycle in which stop is held, -1 none
        int          bst_c;    // cycle with a spurious start while busy, -1 none
        int          exp_cnt;  // expected number of en pulses
        bit          exp_ab;   // expected aborted flag
        string       name;
    } job_t;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] build_m(input logic [95:0] t, input logic [31:0] n, input bit sw);
        logic [31:0] w3;
        w3 = sw ? {n[7:0], n[15:8], n[23:16], n[31:24]} : n;
        return {t, w3, 32'h8000_0000, 320'd0, 32'h0000_0280};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".en"}, 512'(en), 512'(0));
        check({tag, ".nonce"}, 512'(nonce), 512'(0));
        check({tag, ".M"}, M, 512'(0));
        check({tag, ".Hin"}, 512'(Hin), 512'(0));
        check({tag, ".busy"}, 512'(busy), 512'(0));
        check({tag, ".done"}, 512'(done), 512'(0));
        check({tag, ".aborted"}, 512'(aborted), 512'(0));
        check({tag, ".M_sw"}, m_s, 512'(0));
    endtask

    // Runs one job from IDLE; returns after the cycle following done.
    task automatic run_job(input logic [31:0] first, input logic [31:0] last,
                           input int stop_c, input int bst_c,
                           input int exp_cnt, input bit exp_ab, input string name);
        logic [255:0] mid;
        logic [95:0]  tl;
        logic [31:0]  cur;
        int n, cnt, last_issue, end_c, obs;
        bit ab, exp_en, seen;

        n          = int'(last - first) + 1;
        last_issue = 1 + (n - 1) * G;
        if (stop_c >= 1 && stop_c <= last_issue) begin
            cnt   = (stop_c - 1) / G + 1;
            ab    = (stop_c != last_issue);
            end_c = stop_c + 1;
        end else begin
            cnt   = n;
            ab    = 1'b0;
            end_c = last_issue + 1;
        end

        mid = rand256();
        tl  = {$urandom, $urandom, $urandom};
        @(negedge clk);
        midstate    = mid;
        hdr_tail    = tl;
        nonce_first = first;
        nonce_last  = last;
        start       = 1'b1;
        stop        = 1'b0;
        obs  = 0;
        seen = 1'b0;
        cur  = first;

        for (int k = 1; k <= end_c + 1; k++) begin
            @(negedge clk);
            exp_en = ((k - 1) % G == 0) && ((k - 1) / G < cnt);
            check($sformatf("%s.en@%0d", name, k), 512'(en), 512'(exp_en));
            check($sformatf("%s.en_sw@%0d", name, k), 512'(en_s), 512'(exp_en));
            if (en) obs++;
            if (exp_en) begin
                cur  = first + 32'((k - 1) / G);
                seen = 1'b1;
                $display("job %s cycle %0d: en nonce=%h", name, k, nonce);
            end
            if (seen) begin
                check($sformatf("%s.nonce@%0d", name, k), 512'(nonce), 512'(cur));
                check($sformatf("%s.nonce_sw@%0d", name, k), 512'(nonce_s), 512'(cur));
                check($sformatf("%s.M@%0d", name, k), M, build_m(tl, cur, 1'b0));
                check($sformatf("%s.M_sw@%0d", name, k), m_s, build_m(tl, cur, 1'b1));
                check($sformatf("%s.Hin@%0d", name, k), 512'(Hin), 512'(mid));
                check($sformatf("%s.Hin_sw@%0d", name, k), 512'(hin_s), 512'(mid));
            end
            check($sformatf("%s.done@%0d", name, k), 512'(done), 512'(k == end_c));
            check($sformatf("%s.done_sw@%0d", name, k), 512'(done_s), 512'(k == end_c));
            check($sformatf("%s.busy@%0d", name, k), 512'(busy), 512'(k < end_c));
            check($sformatf("%s.busy_sw@%0d", name, k), 512'(busy_s), 512'(k < end_c));
            if (k >= end_c) begin
                check($sformatf("%s.aborted@%0d", name, k), 512'(aborted), 512'(exp_ab));
                check($sformatf("%s.aborted_sw@%0d", name, k), 512'(aborted_s), 512'(ab));
            end
            start = (k == bst_c);
            stop  = (k == stop_c);
            if (k == bst_c) begin
                // different job on the ports; must be ignored
                midstate    = ~mid;
                hdr_tail    = ~tl;
                nonce_first = first + 32'd100;
                nonce_last  = first + 32'd200;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        check({name, ".en_count"}, 512'(obs), 512'(exp_cnt));
    endtask

    job_t jobs[8];

    initial begin
        logic [31:0] f;
        int span, sc, ab_cnt;
        bit ab_r;

        jobs[0] = '{32'd5,          32'd8,          -1, -1, 4, 1'b0, "range5_8"};
        jobs[1] = '{32'hFFFF_FFFE,  32'd1,          -1, -1, 4, 1'b0, "wrap"};
        jobs[2] = '{32'h0000_1234,  32'h0000_1234,  -1, -1, 1, 1'b0, "single"};
        jobs[3] = '{32'd0,          32'd100,         3, -1, 1, 1'b1, "stop_gap2"};
        jobs[4] = '{32'd10,         32'd12,          9, -1, 3, 1'b0, "stop_on_last"};
        jobs[5] = '{32'd10,         32'd20,          5, -1, 2, 1'b1, "stop_in_issue"};
        jobs[6] = '{32'd5,          32'd8,          -1,  3, 4, 1'b0, "start_busy"};
        jobs[7] = '{32'h1122_3344,  32'h1122_3345,  -1, -1, 2, 1'b0, "bswap"};

        reset = 1'b1; start = 1'b0; stop = 1'b0;
        midstate = '0; hdr_tail = '0; nonce_first = '0; nonce_last = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int j = 0; j < 8; j++) begin
            run_job(jobs[j].first, jobs[j].last, jobs[j].stop_c, jobs[j].bst_c,
                    jobs[j].exp_cnt, jobs[j].exp_ab, jobs[j].name);
            repeat (2) @(negedge clk);
        end

        for (int r = 0; r < 8; r++) begin
            f    = $urandom;
            span = int'($urandom_range(0, 4));
            sc   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, span * G + 1)) : -1;
            // expected count and abort from the issue rules
            if (sc >= 1 && sc <= 1 + span * G) begin
                ab_cnt = (sc - 1) / G + 1;
                ab_r   = (sc != 1 + span * G);
            end else begin
                ab_cnt = span + 1;
                ab_r   = 1'b0;
            end
            run_job(f, f + 32'(span), sc, -1, ab_cnt, ab_r, $sformatf("rand%0d", r));
            @(negedge clk);
        end

        // start and stop together in IDLE: nothing starts
        nonce_first = 32'd1; nonce_last = 32'd3;
        start = 1'b1; stop = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0;
            check($sformatf("startstop.en@%0d", k), 512'(en), 512'(0));
            check($sformatf("startstop.busy@%0d", k), 512'(busy), 512'(0));
            check($sformatf("startstop.done@%0d", k), 512'(done), 512'(0));
        end

        // reset in the middle of a GAP: back to zero, no done pulse
        midstate = rand256(); hdr_tail = {$urandom, $urandom, $urandom};
        nonce_first = 32'd0; nonce_last = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rstgap.en1", 512'(en), 512'(1));
        repeat (2) @(negedge clk);
        check("rstgap.busy3", 512'(busy), 512'(1));
        check("rstgap.en3", 512'(en), 512'(0));
        reset = 1'b1;
        @(negedge clk);
        check_zero("rstgap");
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("rstgap.post_en@%0d", k), 512'(en), 512'(0));
            check($sformatf("rstgap.post_done@%0d", k), 512'(done), 512'(0));
            check($sformatf("rstgap.post_busy@%0d", k), 512'(busy), 512'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
